// File: rtl/alushifter_pkg.sv
// Shared types and constants for the alushifter command sequencer.
// Commands carry a worst-case-width repeat field; the sequencer zero-extends its own count.
package alushifter_pkg;

  localparam int unsigned MODE_SHIFT_BIT = 3;
  localparam int unsigned RPT_W          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             load;
    logic [3:0]       mode;
    logic [3:0]       b;
    logic             cin;
    logic [RPT_W-1:0] rpt;
  } cmd_t;

endpackage

// File: rtl/alushifter_cmd_fifo.sv
// Synchronous command FIFO, pointer plus occupancy count; DEPTH must be a power of two.
module alushifter_cmd_fifo
  import alushifter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/alushifter_seq.sv
// Command-driven sequencer: buffers commands and runs each one (rpt+1 times) against a 4-bit
// accumulator through an external alushifter datapath.
module alushifter_seq
  import alushifter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [3:0]       cmd_mode,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_cin,
  input  logic [CNT_W-1:0] cmd_rpt,
  input  logic             clr_ovf,
  output logic [3:0]       dp_a,
  output logic [3:0]       dp_b,
  output logic             dp_cin,
  output logic [3:0]       dp_mode,
  input  logic [3:0]       dp_r,
  input  logic             dp_ovf,
  output logic [3:0]       acc,
  output logic             ovf_sticky,
  output logic             busy,
  output logic             res_valid
);

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty, fifo_pop;

  state_e           state_q, state_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             cur_load_q, cur_load_d;
  logic [3:0]       cur_mode_q, cur_mode_d;
  logic [3:0]       cur_b_q, cur_b_d;
  logic             cur_cin_q, cur_cin_d;

  assign cmd_ready = ~fifo_full;
  assign push_cmd  = '{load: cmd_load, mode: cmd_mode, b: cmd_b, cin: cmd_cin,
                       rpt: RPT_W'(cmd_rpt)};

  alushifter_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid & cmd_ready),
    .pop   (fifo_pop),
    .wdata (push_cmd),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_d      = clr_ovf ? 1'b0 : ovf_q;
    cur_load_d = cur_load_q;
    cur_mode_d = cur_mode_q;
    cur_b_d    = cur_b_q;
    cur_cin_d  = cur_cin_q;
    fifo_pop   = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_load_d = head_cmd.load;
          cur_mode_d = head_cmd.mode;
          cur_b_d    = head_cmd.b;
          cur_cin_d  = head_cmd.cin;
          cnt_d      = head_cmd.rpt;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cur_load_q) begin
          acc_d   = cur_b_q;
          state_d = DONE;
        end else begin
          acc_d = dp_r;
          // Shifter modes leave overflow floating, so only a definite 1 in ALU mode counts.
          if (!cur_mode_q[MODE_SHIFT_BIT] && (dp_ovf === 1'b1)) ovf_d = 1'b1;
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cur_load_q <= 1'b0;
      cur_mode_q <= '0;
      cur_b_q    <= '0;
      cur_cin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cur_load_q <= cur_load_d;
      cur_mode_q <= cur_mode_d;
      cur_b_q    <= cur_b_d;
      cur_cin_q  <= cur_cin_d;
    end
  end

  assign dp_a       = acc_q;
  assign dp_b       = cur_b_q;
  assign dp_cin     = cur_cin_q;
  assign dp_mode    = cur_mode_q;
  assign acc        = acc_q;
  assign ovf_sticky = ovf_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_alushifter_seq.sv
// Self-checking bench for alushifter_seq with a stub datapath and a queue-based reference model.
module tb_alushifter_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_load, cmd_cin, clr_ovf;
  logic [3:0]       cmd_mode, cmd_b;
  logic [CNT_W-1:0] cmd_rpt;
  logic [3:0]       dp_a, dp_b, dp_mode, dp_r, acc;
  logic             dp_cin, ovf_sticky, busy, res_valid;
  logic             add_ovf;
  logic [4:0]       sum5;
  wire              dp_ovf;

  always #5 clk = ~clk;

  // Stub datapath: ALU adds with carry-in, shifter shifts left and floats overflow.
  always_comb begin
    sum5    = {1'b0, dp_a} + {1'b0, dp_b} + {4'b0, dp_cin};
    dp_r    = dp_mode[3] ? {dp_a[2:0], 1'b0} : sum5[3:0];
    add_ovf = (dp_a[3] == dp_b[3]) && (sum5[3] != dp_a[3]);
  end
  assign dp_ovf = dp_mode[3] ? 1'bz : add_ovf;

  alushifter_seq #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_mode   (cmd_mode),
    .cmd_b      (cmd_b),
    .cmd_cin    (cmd_cin),
    .cmd_rpt    (cmd_rpt),
    .clr_ovf    (clr_ovf),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_cin     (dp_cin),
    .dp_mode    (dp_mode),
    .dp_r       (dp_r),
    .dp_ovf     (dp_ovf),
    .acc        (acc),
    .ovf_sticky (ovf_sticky),
    .busy       (busy),
    .res_valid  (res_valid)
  );

  typedef struct {
    bit       load;
    bit [3:0] mode;
    bit [3:0] b;
    bit       cin;
    int       rpt;
  } tcmd_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_pulses = 0;
  tcmd_t exp_q[$];
  int    m_acc = 0;
  bit    m_ovf = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Whole-command effect on the architectural accumulator and sticky flag.
  function automatic void model_run(input tcmd_t c);
    int s;
    bit sa, sb, ss;
    if (c.load) begin
      m_acc = c.b;
    end else begin
      for (int i = 0; i <= c.rpt; i++) begin
        if (c.mode[3]) begin
          m_acc = (m_acc * 2) % 16;
        end else begin
          s  = m_acc + c.b + c.cin;
          sa = (m_acc >= 8);
          sb = (c.b >= 8);
          ss = ((s % 16) >= 8);
          if (sa == sb && ss != sa) m_ovf = 1'b1;
          m_acc = s % 16;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    tcmd_t c;
    if (rst_n && res_valid) begin
      n_pulses++;
      check_eq("cmd_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        model_run(c);
        check_eq("res_acc", acc, m_acc);
        check_eq("res_ovf", ovf_sticky, m_ovf);
      end
    end
  end

  // Called and returns at a falling edge; the push happens on the rising edge in between.
  task automatic push_cmd(input bit load, input bit [3:0] mode, input bit [3:0] b,
                          input bit cin, input int rpt, output int waited);
    tcmd_t c;
    c = '{load, mode, b, cin, rpt};
    cmd_load  = load;
    cmd_mode  = mode;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_rpt   = rpt[CNT_W-1:0];
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("push_ready", cmd_ready, 1);
    @(posedge clk);
    if (cmd_ready) exp_q.push_back(c);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_busy", busy, 0);
    check_eq("drain_queue", exp_q.size(), 0);
  endtask

  task automatic clear_sticky();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    int w, p0;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_mode  = '0;
    cmd_b     = '0;
    cmd_cin   = 1'b0;
    cmd_rpt   = '0;
    clr_ovf   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_acc", acc, 0);
    check_eq("rst_ovf", ovf_sticky, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_dp", {dp_a, dp_b, dp_mode, dp_cin}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load 3, add 2 three times: 5, 7, 9 with overflow on the last step.
    p0 = n_pulses;
    push_cmd(1'b1, 4'd0, 4'd3, 1'b0, 0, w);
    push_cmd(1'b0, 4'd0, 4'd2, 1'b0, 2, w);
    drain();
    check_eq("t1_acc", acc, 9);
    check_eq("t1_ovf", ovf_sticky, 1);
    check_eq("t1_pulses", n_pulses - p0, 2);
    clear_sticky();
    check_eq("t1_clr", ovf_sticky, 0);

    // Shift 0011 left four times; floating overflow must never stick.
    push_cmd(1'b1, 4'd0, 4'd3, 1'b0, 0, w);
    push_cmd(1'b0, 4'b1000, 4'd0, 1'b0, 3, w);
    drain();
    check_eq("t2_acc", acc, 0);
    check_eq("t2_ovf", ovf_sticky, 0);

    // Latency of a single add from an idle block.
    push_cmd(1'b0, 4'd0, 4'd5, 1'b0, 0, w);
    check_eq("lat_e0_rv", res_valid, 0);
    check_eq("lat_e0_busy", busy, 1);
    check_eq("lat_e0_acc", acc, 0);
    @(negedge clk);
    check_eq("lat_e1_rv", res_valid, 0);
    check_eq("lat_e1_acc", acc, 0);
    @(negedge clk);
    check_eq("lat_e2_rv", res_valid, 1);
    check_eq("lat_e2_acc", acc, 5);
    @(negedge clk);
    check_eq("lat_e3_rv", res_valid, 0);
    check_eq("lat_e3_busy", busy, 0);
    check_eq("lat_hold_b", dp_b, 5);
    check_eq("lat_hold_mode", dp_mode, 0);

    // Six back-to-back commands against a four-entry FIFO.
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b0, 4'd0, 4'(i + 1), 1'b0, 2, w);
      check_eq("bp_nowait", w, 0);
    end
    check_eq("bp_full_ready", cmd_ready, 0);
    check_eq("bp_full_busy", busy, 1);
    push_cmd(1'b0, 4'd0, 4'd6, 1'b0, 2, w);
    check_eq("bp_waited", int'(w > 0), 1);
    drain();
    check_eq("bp_pulses", n_pulses - p0, 6);
    check_eq("bp_acc", acc, 4);

    // Clear coinciding with an overflowing add: the set wins.
    clear_sticky();
    push_cmd(1'b1, 4'd0, 4'd7, 1'b0, 0, w);
    drain();
    push_cmd(1'b0, 4'd0, 4'd1, 1'b0, 0, w);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check_eq("clr_same_ovf", ovf_sticky, 1);
    @(negedge clk);
    check_eq("clr_hold_ovf", ovf_sticky, 1);
    clear_sticky();
    check_eq("clr_idle_ovf", ovf_sticky, 0);
    check_eq("clr_keeps_acc", acc, 8);

    // Asynchronous reset in the middle of a long command.
    push_cmd(1'b0, 4'd0, 4'd1, 1'b0, 5, w);
    repeat (3) @(negedge clk);
    p0 = n_pulses;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_acc", acc, 0);
    check_eq("mid_rst_ovf", ovf_sticky, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    check_eq("mid_rst_rv", res_valid, 0);
    check_eq("mid_rst_dp", {dp_a, dp_b, dp_mode, dp_cin}, 0);
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("mid_rst_no_pulse", n_pulses - p0, 0);
    check_eq("mid_rst_idle", busy, 0);

    // Random command mix with random gaps.
    p0 = n_pulses;
    for (int i = 0; i < 40; i++) begin
      push_cmd(($urandom_range(3) == 0), 4'($urandom), 4'($urandom), 1'($urandom),
               int'($urandom_range(3)), w);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    drain();
    check_eq("rand_pulses", n_pulses - p0, 40);
    check_eq("rand_acc", acc, m_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alushifter_seq.md
Name: alushifter_seq

Overview:
- Command-driven sequencer for the 4-bit ALU/shifter datapath (alushifter).
- Buffers operation commands in a small FIFO and executes each one against an internal 4-bit accumulator, optionally repeating it.
- Drives the datapath operand/mode pins and captures its result and overflow.
- Sits between a command source (counter or control FSM) and one alushifter instance.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- CNT_W, 3, width of repeat field; a command executes rpt+1 times

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_load  in  1  1: acc <= cmd_b, no datapath op
- cmd_mode  in  4  datapath mode (bit3=0 ALU, 1 shifter)
- cmd_b  in  4  operand B or load value
- cmd_cin  in  1  carry-in
- cmd_rpt  in  CNT_W  repeat count
- clr_ovf  in  1  clear sticky overflow
- dp_a  out  4  datapath A (= acc)
- dp_b  out  4  datapath B
- dp_cin  out  1  datapath carry-in
- dp_mode  out  4  datapath mode
- dp_r  in  4  datapath result
- dp_ovf  in  1  datapath overflow (may be z when dp_mode[3]=1)
- acc  out  4  accumulator
- ovf_sticky  out  1  sticky overflow
- busy  out  1  state != IDLE or FIFO non-empty
- res_valid  out  1  one-cycle pulse, command complete

Behaviour:
- Reset (async, rst_n=0): FIFO flushed, state IDLE, acc=0, ovf_sticky=0, res_valid=0, busy=0, cmd_ready=1. Current-command regs are 0, so dp_a, dp_b, dp_mode and dp_cin are all 0. Reset mid-EXEC abandons the command with no res_valid.
- Push: occurs when cmd_valid & cmd_ready at a clock edge. cmd_ready = !full. A pop in the same cycle does not free space for that cycle's push.
- FSM IDLE -> EXEC:
  - Taken when the FIFO is non-empty.
  - On that edge the head entry is popped into the current-command regs, cnt <= rpt.
- FSM EXEC, load command:
  - acc <= cur_b once; rpt ignored.
  - Next state DONE.
- FSM EXEC, op command:
  - Each edge: acc <= dp_r.
  - ovf_sticky set if cur_mode[3]==0 && dp_ovf===1'b1. Shifter-mode z/x overflow is never sampled.
  - If cnt==0, next state DONE; else cnt <= cnt-1 and stay in EXEC.
- FSM DONE: res_valid=1 for exactly this cycle, then IDLE.
- Latency, rpt=0, empty idle FIFO:
  - Push at edge E0, pop at E1, acc update at E2.
  - res_valid high between E2 and E3.
  - Each extra repeat adds one cycle.
- Datapath pin mapping:
  - dp_a = acc, combinational from regs.
  - dp_b / dp_mode / dp_cin = current-command regs, held after completion.
- Width: all arithmetic is performed by the datapath, mod 16. The sequencer adds nothing.
- clr_ovf: clears ovf_sticky; a set in the same cycle wins. clr_ovf does not affect acc.
- Commands complete strictly in FIFO order.

Decomposition:
- Shared package alushifter_pkg:
  - State enum (IDLE, EXEC, DONE).
  - Constant MODE_SHIFT_BIT = 3.
  - Command record (load, mode, b, cin, rpt).
- Sub-module alushifter_cmd_fifo:
  - Synchronous FIFO, DEPTH entries, pointer+count.
  - Ports: push, pop, full, empty, data.
- alushifter itself is instantiated by the parent, not inside this block.

Test Plan:
- Bench stub datapath model:
  - mode[3]=0: dp_r = a+b mod 16, dp_ovf = signed add overflow.
  - mode[3]=1: dp_r = a<<1, dp_ovf = z.
- Load 3, then add b=2 rpt=2:
  - acc goes 3 -> 5 -> 7 -> 9.
  - ovf_sticky goes 1 on the 7+2 step.
  - Two res_valid pulses.
- Load 4'b0011, then mode 4'b1000 rpt=3:
  - acc goes 0110, 1100, 1000, 0000.
  - ovf_sticky stays 0.
- Single add rpt=0 pushed at E0 into idle block:
  - acc updates at E2.
  - res_valid high exactly one cycle after E2.
  - busy falls after DONE.
- Back-to-back pushes of 6 commands while first executes:
  - cmd_ready drops when 4 are buffered.
  - Remaining commands are accepted only after pops.
  - All 6 complete in order with 6 res_valid pulses.
- clr_ovf asserted in same cycle as an overflowing add:
  - ovf_sticky = 1.
  - clr_ovf next idle cycle gives 0.
- rst_n pulsed low mid-EXEC of rpt=5:
  - All outputs return to reset values immediately.
  - FIFO empty, no res_valid.
